am4_qram: RTL and testbench

Q-bus slave static RAM for the am4 Q-bus processor system. It sits directly downstream of the processor bus interface and consumes its SYNC/DIN/DOUT/WTBT/IAKO strobes and multiplexed address/data. It decodes a configurable address window and serves word and byte reads and writes, including read-modify-write, from an internal synchronous memory array. It answers each data strobe with RPLY after a programmable number of wait states.

---
 rtl/am4_qram_if.sv | 22 ++
 rtl/am4_qram.sv | 156 +++++++++++++++
 tb/tb_am4_qram.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/am4_qram_if.sv
// rtl/am4_qram_if.sv - Q-bus slave strobe, address/data and reply bundle for am4_qram
interface am4_qram_if;
    logic [15:0] pin_ad_in;
    logic        pin_sync;
    logic        pin_din;
    logic        pin_dout;
    logic        pin_wtbt;
    logic        pin_iako;
    logic        pin_rply;
    logic [15:0] pin_ad_out;
    logic        pin_ad_ena;

    modport master (
        output pin_ad_in, pin_sync, pin_din, pin_dout, pin_wtbt, pin_iako,
        input  pin_rply, pin_ad_out, pin_ad_ena
    );

    modport slave (
        input  pin_ad_in, pin_sync, pin_din, pin_dout, pin_wtbt, pin_iako,
        output pin_rply, pin_ad_out, pin_ad_ena
    );
endinterface

// File: rtl/am4_qram.sv
// rtl/am4_qram.sv - Q-bus slave static RAM with address window, byte writes and wait states
module am4_qram #(
    parameter int          RAM_AW = 12,
    parameter logic [15:0] BASE   = 16'o000000,
    parameter int          WAIT   = 0
) (
    input  logic pin_clk,
    input  logic pin_init,
    am4_qram_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, UNSEL, SEL, WAITS_R, WAITS_W, RPLY_R, RPLY_W
    } state_t;

    // Only address bits above the in-window byte offset take part in the decode.
    localparam logic [15:0] WIN_MASK = 16'(32'hFFFF << (RAM_AW + 1));

    state_t            state, state_d;
    logic              sync_q;
    logic [RAM_AW:0]   a_q;
    logic [3:0]        cnt, cnt_d;
    logic              rply_q, rply_d;
    logic              ena_q, ena_d;
    logic [15:0]       out_q;
    logic [15:0]       rd_data;
    logic              latch, rd_en, wr_en, out_ld;
    logic              hit;
    logic [RAM_AW-1:0] idx;
    logic [15:0]       mem [2**RAM_AW];

    assign idx = a_q[RAM_AW:1];
    assign hit = (((bus.pin_ad_in ^ BASE) & WIN_MASK) == 16'h0) && !bus.pin_iako;

    assign bus.pin_rply   = rply_q;
    assign bus.pin_ad_ena = ena_q;
    assign bus.pin_ad_out = out_q;

    always_ff @(posedge pin_clk) begin
        if (pin_init) begin
            state  <= IDLE;
            sync_q <= 1'b0;
            cnt    <= 4'd0;
            rply_q <= 1'b0;
            ena_q  <= 1'b0;
            out_q  <= 16'h0;
        end else begin
            state  <= state_d;
            sync_q <= bus.pin_sync;
            cnt    <= cnt_d;
            rply_q <= rply_d;
            ena_q  <= ena_d;
            if (out_ld) out_q <= rd_data;
            if (latch)  a_q   <= bus.pin_ad_in[RAM_AW:0];
        end
    end

    // Array: read is issued when DIN is accepted so data is ready by the reply edge.
    always_ff @(posedge pin_clk) begin
        if (rd_en) rd_data <= mem[idx];
        if (wr_en && !pin_init) begin
            if (!bus.pin_wtbt || !a_q[0]) mem[idx][7:0]  <= bus.pin_ad_in[7:0];
            if (!bus.pin_wtbt ||  a_q[0]) mem[idx][15:8] <= bus.pin_ad_in[15:8];
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rply_d  = rply_q;
        ena_d   = ena_q;
        latch   = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        out_ld  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.pin_sync && !sync_q) begin
                    latch   = 1'b1;
                    state_d = hit ? SEL : UNSEL;
                end
            end
            UNSEL: begin
                if (!bus.pin_sync) state_d = IDLE;
            end
            SEL: begin
                if (!bus.pin_sync) begin
                    state_d = IDLE;
                end else if (bus.pin_din) begin
                    cnt_d   = 4'(WAIT);
                    rd_en   = 1'b1;
                    state_d = WAITS_R;
                end else if (bus.pin_dout) begin
                    cnt_d   = 4'(WAIT);
                    state_d = WAITS_W;
                end
            end
            WAITS_R: begin
                if (!bus.pin_sync) begin
                    state_d = IDLE;
                    rply_d  = 1'b0;
                    ena_d   = 1'b0;
                end else if (cnt == 4'd0) begin
                    out_ld  = 1'b1;
                    rply_d  = 1'b1;
                    ena_d   = 1'b1;
                    state_d = RPLY_R;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            WAITS_W: begin
                // An abort here must never commit the pending write.
                if (!bus.pin_sync) begin
                    state_d = IDLE;
                    rply_d  = 1'b0;
                    ena_d   = 1'b0;
                end else if (cnt == 4'd0) begin
                    wr_en   = 1'b1;
                    rply_d  = 1'b1;
                    state_d = RPLY_W;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            RPLY_R: begin
                if (!bus.pin_sync) begin
                    state_d = IDLE;
                    rply_d  = 1'b0;
                    ena_d   = 1'b0;
                end else if (!bus.pin_din) begin
                    state_d = SEL;
                    rply_d  = 1'b0;
                    ena_d   = 1'b0;
                end
            end
            RPLY_W: begin
                if (!bus.pin_sync) begin
                    state_d = IDLE;
                    rply_d  = 1'b0;
                    ena_d   = 1'b0;
                end else if (!bus.pin_dout) begin
                    state_d = SEL;
                    rply_d  = 1'b0;
                    ena_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rply_d  = 1'b0;
                ena_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_am4_qram.sv
// tb/tb_am4_qram.sv - scoreboard bench for am4_qram with zero and three wait states
module tb_am4_qram;

    logic clk = 1'b0;
    logic init;
    always #5 clk = ~clk;

    am4_qram_if b0();
    am4_qram_if b1();

    assign b1.pin_ad_in = b0.pin_ad_in;
    assign b1.pin_sync  = b0.pin_sync;
    assign b1.pin_din   = b0.pin_din;
    assign b1.pin_dout  = b0.pin_dout;
    assign b1.pin_wtbt  = b0.pin_wtbt;
    assign b1.pin_iako  = b0.pin_iako;

    am4_qram #(.RAM_AW(12), .BASE(16'o000000), .WAIT(0)) dut0 (
        .pin_clk (clk),
        .pin_init(init),
        .bus     (b0)
    );

    am4_qram #(.RAM_AW(12), .BASE(16'o000000), .WAIT(3)) dut1 (
        .pin_clk (clk),
        .pin_init(init),
        .bus     (b1)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] model [4096];
    logic [15:0] sb [$];
    logic [15:0] cur_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
        end
    endtask

    function automatic logic rply_of(input int which);
        return (which == 0) ? b0.pin_rply : b1.pin_rply;
    endfunction

    function automatic logic ena_of(input int which);
        return (which == 0) ? b0.pin_ad_ena : b1.pin_ad_ena;
    endfunction

    function automatic logic [15:0] out_of(input int which);
        return (which == 0) ? b0.pin_ad_out : b1.pin_ad_out;
    endfunction

    task automatic mdl_write(input logic [15:0] d, input logic bw);
        logic [15:0] w;
        w = model[cur_a[12:1]];
        if (!bw)           w = d;
        else if (cur_a[0]) w[15:8] = d[15:8];
        else               w[7:0] = d[7:0];
        model[cur_a[12:1]] = w;
    endtask

    task automatic start_cycle(input logic [15:0] a, input logic wr, input logic ia);
        @(negedge clk);
        cur_a        = a;
        b0.pin_ad_in = a;
        b0.pin_wtbt  = wr;
        b0.pin_iako  = ia;
        b0.pin_din   = 1'b0;
        b0.pin_dout  = 1'b0;
        b0.pin_sync  = 1'b1;
    endtask

    task automatic end_cycle();
        @(negedge clk);
        b0.pin_sync = 1'b0;
        b0.pin_din  = 1'b0;
        b0.pin_dout = 1'b0;
        b0.pin_wtbt = 1'b0;
        b0.pin_iako = 1'b0;
    endtask

    task automatic strobe(input int which, input logic rd, input logic [15:0] d, input logic bw);
        int          n;
        logic        got;
        logic [15:0] exp;
        @(negedge clk);
        if (rd) begin
            sb.push_back(model[cur_a[12:1]]);
            b0.pin_ad_in = 16'h0;
            b0.pin_wtbt  = 1'b0;
            b0.pin_din   = 1'b1;
        end else begin
            b0.pin_ad_in = d;
            b0.pin_wtbt  = bw;
            b0.pin_dout  = 1'b1;
            mdl_write(d, bw);
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            got = rply_of(which);
        end
        chk(rd ? "rd_latency" : "wr_latency", n, (which == 0) ? 2 : 5);
        if (rd) begin
            exp = sb.pop_front();
            if (got) begin
                chk("rd_data", out_of(which), exp);
                chk("rd_ena", ena_of(which), 1);
            end
        end
    endtask

    task automatic release_strobe(input int which);
        @(negedge clk);
        b0.pin_din  = 1'b0;
        b0.pin_dout = 1'b0;
        @(negedge clk);
        chk("rply_fall", rply_of(which), 0);
        chk("ena_fall", ena_of(which), 0);
    endtask

    task automatic xact(input int which, input logic [15:0] a, input logic rd,
                        input logic [15:0] d, input logic bw);
        start_cycle(a, !rd, 1'b0);
        strobe(which, rd, d, bw);
        release_strobe(which);
        end_cycle();
    endtask

    task automatic count_rply(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (b0.pin_rply || b1.pin_rply) hits++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        init         = 1'b1;
        b0.pin_ad_in = 16'h0;
        b0.pin_sync  = 1'b0;
        b0.pin_din   = 1'b0;
        b0.pin_dout  = 1'b0;
        b0.pin_wtbt  = 1'b0;
        b0.pin_iako  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rply", b0.pin_rply, 0);
        chk("rst_ena", b0.pin_ad_ena, 0);
        chk("rst_ad_out", b0.pin_ad_out, 0);
        chk("rst_rply_w3", b1.pin_rply, 0);
        init = 1'b0;

        // word write/read
        xact(0, 16'o000100, 1'b0, 16'o123456, 1'b0);
        xact(0, 16'o000100, 1'b1, 16'h0, 1'b0);

        // byte lanes
        xact(0, 16'o000100, 1'b0, 16'o000000, 1'b0);
        xact(0, 16'o000101, 1'b0, 16'o177400, 1'b1);
        xact(0, 16'o000100, 1'b1, 16'h0, 1'b0);
        xact(0, 16'o000100, 1'b0, 16'o000252, 1'b1);
        xact(0, 16'o000100, 1'b1, 16'h0, 1'b0);

        // window edges
        xact(0, 16'o017776, 1'b0, 16'o070707, 1'b0);
        xact(0, 16'o000000, 1'b0, 16'o001234, 1'b0);
        xact(0, 16'o017776, 1'b1, 16'h0, 1'b0);
        xact(0, 16'o000000, 1'b1, 16'h0, 1'b0);

        // out of window
        start_cycle(16'o020000, 1'b0, 1'b0);
        @(negedge clk);
        b0.pin_din = 1'b1;
        count_rply(20, hits);
        chk("oow_rply", hits, 0);
        end_cycle();

        // interrupt acknowledge cycle must not be selected
        start_cycle(16'o000100, 1'b1, 1'b1);
        @(negedge clk);
        b0.pin_ad_in = 16'o000777;
        b0.pin_wtbt  = 1'b0;
        b0.pin_dout  = 1'b1;
        count_rply(20, hits);
        chk("iako_rply", hits, 0);
        end_cycle();
        xact(0, 16'o000100, 1'b1, 16'h0, 1'b0);

        // three wait states
        xact(1, 16'o000200, 1'b0, 16'o055555, 1'b0);
        xact(1, 16'o000200, 1'b1, 16'h0, 1'b0);

        // read-modify-write in one SYNC
        xact(0, 16'o000300, 1'b0, 16'o000001, 1'b0);
        start_cycle(16'o000300, 1'b0, 1'b0);
        strobe(0, 1'b1, 16'h0, 1'b0);
        release_strobe(0);
        strobe(0, 1'b0, 16'o000002, 1'b0);
        release_strobe(0);
        end_cycle();
        xact(0, 16'o000300, 1'b1, 16'h0, 1'b0);

        // init while the slow slave is still waiting to commit
        start_cycle(16'o000200, 1'b1, 1'b0);
        @(negedge clk);
        b0.pin_ad_in = 16'o011111;
        b0.pin_dout  = 1'b1;
        @(negedge clk);
        init        = 1'b1;
        b0.pin_sync = 1'b0;
        b0.pin_dout = 1'b0;
        @(negedge clk);
        chk("init_rply", b1.pin_rply, 0);
        init = 1'b0;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b1.pin_rply) hits++;
        end
        chk("init_no_rply", hits, 0);
        end_cycle();
        xact(1, 16'o000200, 1'b1, 16'h0, 1'b0);

        // SYNC dropped while the read reply is held
        start_cycle(16'o000300, 1'b0, 1'b0);
        strobe(0, 1'b1, 16'h0, 1'b0);
        @(negedge clk);
        b0.pin_sync = 1'b0;
        @(negedge clk);
        chk("abort_rply", b0.pin_rply, 0);
        chk("abort_ena", b0.pin_ad_ena, 0);
        end_cycle();
        xact(0, 16'o000300, 1'b1, 16'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
